lmul_sequencer: RTL and testbench



---
 rtl/lmul_sequencer_pkg.sv | 12 +
 rtl/lmul_step.sv | 31 +++
 rtl/lmul_sequencer.sv | 177 +++++++++++++++++
 tb/tb_lmul_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lmul_sequencer_pkg.sv
// rtl/lmul_sequencer_pkg.sv - shared state encoding and width default for the long-multiply sequencer
package lmul_sequencer_pkg;

    localparam int LMUL_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lmul_state_t;

endpackage

// File: rtl/lmul_step.sv
// rtl/lmul_step.sv - one combinational add-and-shift iteration of the long multiply
//   mcand   : multiplicand magnitude
//   acc_hi  : upper accumulator half
//   acc_lo  : lower accumulator half; its unconsumed low bits are the multiplier
//   hi_next : upper half after conditional add and right shift
//   lo_next : lower half after right shift
module lmul_step
    import lmul_sequencer_pkg::*;
#(
    parameter int WIDTH = LMUL_WIDTH
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, acc_hi};
        if (acc_lo[0]) begin
            sum = {1'b0, acc_hi} + {1'b0, mcand};
        end
        // {carry, sum, acc_lo} shifted right by one
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], acc_lo[WIDTH-1:1]};
    end

endmodule

// File: rtl/lmul_sequencer.sv
// rtl/lmul_sequencer.sv - multi-cycle UMULL/SMULL sequencer with pipeline stall and dual write addresses
//   clk, reset          : clock, synchronous active-high reset
//   StartE, SignedE     : long-multiply request, 1 = SMULL
//   SrcAE, SrcBE        : multiplicand, multiplier
//   WA3E, WA3_2E        : low/high word destinations
//   AbortE              : E-stage flush
//   StallMul, BusyMul   : stall request to hazard unit, sequencer not idle
//   DoneMul             : one-cycle result-valid pulse
//   ResultLo, ResultHi  : 2*WIDTH-bit product
//   WA3Mul, WA3_2Mul    : destinations matching the result
//   LMUL_EARLY_TERM_EN  : when defined, finish as soon as the remaining multiplier bits are zero
module lmul_sequencer
    import lmul_sequencer_pkg::*;
#(
    parameter int WIDTH = LMUL_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic             SignedE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3_2E,
    input  logic             AbortE,
    output logic             StallMul,
    output logic             BusyMul,
    output logic             DoneMul,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [3:0]       WA3Mul,
    output logic [3:0]       WA3_2Mul
);

    lmul_state_t state, state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         wa_lo;
    logic [3:0]         wa_hi;

    logic               start_ok;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [WIDTH-1:0]   run_hi;
    logic [WIDTH-1:0]   run_lo;
    logic               last_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_final;

    assign start_ok = StartE & ~AbortE;

    // Magnitudes; the most negative value maps to 2^(WIDTH-1) as unsigned
    assign abs_a = (SignedE && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    assign abs_b = (SignedE && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

    lmul_step #(.WIDTH(WIDTH)) u_step (
        .mcand   (mcand),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

`ifdef LMUL_EARLY_TERM_EN
    logic [WIDTH-1:0]   rem_mask;
    logic [2*WIDTH-1:0] skip_shift;

    // After this step the unconsumed multiplier bits are step_lo[cnt-1:0].
    // If they are all zero the remaining iterations are pure shifts.
    always_comb begin
        rem_mask   = ~({WIDTH{1'b1}} << cnt);
        skip_shift = {step_hi, step_lo} >> cnt;
        last_step  = ((step_lo & rem_mask) == '0);
        run_hi     = step_hi;
        run_lo     = step_lo;
        if (last_step) begin
            run_hi = skip_shift[2*WIDTH-1:WIDTH];
            run_lo = skip_shift[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        last_step = (cnt == '0);
        run_hi    = step_hi;
        run_lo    = step_lo;
    end
`endif

    assign prod       = {acc_hi, acc_lo};
    assign prod_final = neg ? -prod : prod;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_ok) state_next = ST_RUN;
            ST_RUN: begin
                if (AbortE) begin
                    state_next = ST_IDLE;
                end else if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs; the request cycle already stalls so the instruction holds in E
    always_comb begin
        StallMul = ((state == ST_IDLE) && start_ok) || (state == ST_RUN);
        BusyMul  = (state != ST_IDLE);
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            wa_lo    <= '0;
            wa_hi    <= '0;
            DoneMul  <= 1'b0;
            ResultLo <= '0;
            ResultHi <= '0;
            WA3Mul   <= '0;
            WA3_2Mul <= '0;
        end else begin
            DoneMul <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        mcand  <= abs_a;
                        acc_hi <= '0;
                        acc_lo <= abs_b;
                        neg    <= (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]) & SignedE;
                        cnt    <= CNT_W'(WIDTH - 1);
                        wa_lo  <= WA3E;
                        wa_hi  <= WA3_2E;
                    end
                end
                ST_RUN: begin
                    acc_hi <= run_hi;
                    acc_lo <= run_lo;
                    cnt    <= cnt - CNT_W'(1);
                end
                ST_DONE: begin
                    ResultLo <= prod_final[WIDTH-1:0];
                    ResultHi <= prod_final[2*WIDTH-1:WIDTH];
                    WA3Mul   <= wa_lo;
                    WA3_2Mul <= wa_hi;
                    DoneMul  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lmul_sequencer.sv
// tb/tb_lmul_sequencer.sv - randomized self-checking bench for lmul_sequencer
module tb_lmul_sequencer;

    logic        clk;
    logic        reset;
    logic        StartE;
    logic        SignedE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [3:0]  WA3E;
    logic [3:0]  WA3_2E;
    logic        AbortE;
    logic        StallMul;
    logic        BusyMul;
    logic        DoneMul;
    logic [31:0] ResultLo;
    logic [31:0] ResultHi;
    logic [3:0]  WA3Mul;
    logic [3:0]  WA3_2Mul;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_lo = '0;
    logic [31:0] exp_hi = '0;
    logic [3:0]  exp_wa = '0;
    logic [3:0]  exp_wa2 = '0;

    lmul_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .StartE   (StartE),
        .SignedE  (SignedE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .WA3E     (WA3E),
        .WA3_2E   (WA3_2E),
        .AbortE   (AbortE),
        .StallMul (StallMul),
        .BusyMul  (BusyMul),
        .DoneMul  (DoneMul),
        .ResultLo (ResultLo),
        .ResultHi (ResultHi),
        .WA3Mul   (WA3Mul),
        .WA3_2Mul (WA3_2Mul)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_lo"},  ResultLo, exp_lo);
        check({tag, "_hi"},  ResultHi, exp_hi);
        check({tag, "_wa"},  WA3Mul,   exp_wa);
        check({tag, "_wa2"}, WA3_2Mul, exp_wa2);
    endtask

    // mode: 0 plain, 1 second StartE during RUN, 2 AbortE during RUN, 3 reset during RUN
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [3:0] w1, input logic [3:0] w2,
                          input int mode, input int at);
        logic [63:0] prod;
        logic [31:0] mb;
        longint      sa, sb;
        int          runs, stalls, done_at, done_cnt;

        if (sgn) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            prod = 64'(sa * sb);
        end else begin
            prod = {32'd0, a} * {32'd0, b};
        end
        mb = (sgn && b[31]) ? (~b + 32'd1) : b;
`ifdef LMUL_EARLY_TERM_EN
        runs = 1;
        for (int i = 0; i < 32; i++) if (mb[i]) runs = i + 1;
`else
        runs = 32;
`endif

        StartE = 1'b1; SignedE = sgn; SrcAE = a; SrcBE = b;
        WA3E = w1; WA3_2E = w2; AbortE = 1'b0;
        #1;
        check("stall_req", StallMul, 1'b1);
        @(posedge clk); #1;

        stalls = 1; done_at = -1; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            StartE = (mode == 1 && c == at);
            AbortE = (mode == 2 && c == at);
            reset  = (mode == 3 && c == at);
            SrcAE  = $urandom; SrcBE = $urandom;
            WA3E   = 4'($urandom); WA3_2E = 4'($urandom);
            #1;
            if (StallMul) stalls++;
            if (DoneMul) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if ((mode == 2 || mode == 3) && c == at + 1)
                check("busy_after_cancel", BusyMul, 1'b0);
            if (mode == 3 && c == at + 1) begin
                exp_lo = '0; exp_hi = '0; exp_wa = '0; exp_wa2 = '0;
                check_results("reset_mid");
                check("reset_done", DoneMul, 1'b0);
                check("reset_stall", StallMul, 1'b0);
            end
            @(posedge clk); #1;
        end
        StartE = 1'b0; AbortE = 1'b0; reset = 1'b0;
        #1;

        if (mode == 0 || mode == 1) begin
            check("done_latency", 64'(done_at), 64'(runs + 1));
            check("done_count",   64'(done_cnt), 64'd1);
            check("stall_cycles", 64'(stalls), 64'(runs + 1));
            exp_lo = prod[31:0]; exp_hi = prod[63:32]; exp_wa = w1; exp_wa2 = w2;
            check_results("mul");
        end else begin
            check("cancel_no_done", 64'(done_cnt), 64'd0);
            check_results("cancel_keep");
        end
        check("busy_end", BusyMul, 1'b0);
    endtask

    initial begin
        reset = 1'b1; StartE = 1'b0; SignedE = 1'b0; SrcAE = '0; SrcBE = '0;
        WA3E = '0; WA3_2E = '0; AbortE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  BusyMul,  1'b0);
        check("rst_stall", StallMul, 1'b0);
        check("rst_done",  DoneMul,  1'b0);
        check_results("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        do_mul(32'd3, 32'd5, 1'b0, 4'd1, 4'd4, 0, 0);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd2, 4'd3, 0, 0);
        do_mul(32'hFFFF_FFFF, 32'd1, 1'b1, 4'd5, 4'd6, 0, 0);
        do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd7, 4'd8, 0, 0);
        do_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 4'd9, 4'd10, 1, 10);
        do_mul(32'h0000_DEAD, 32'h8000_0001, 1'b0, 4'd11, 4'd12, 2, 5);
        do_mul(32'h0000_1111, 32'hF000_0000, 1'b0, 4'd13, 4'd14, 3, 7);
        do_mul(32'd7, 32'd1, 1'b0, 4'd15, 4'd0, 0, 0);
        do_mul(32'hABCD_0001, 32'd0, 1'b1, 4'd3, 4'd2, 0, 0);

        // StartE together with AbortE in IDLE: abort wins
        StartE = 1'b1; AbortE = 1'b1; SrcAE = 32'd9; SrcBE = 32'd9;
        WA3E = 4'd1; WA3_2E = 4'd1;
        #1;
        check("start_abort_stall", StallMul, 1'b0);
        @(posedge clk); #1;
        StartE = 1'b0; AbortE = 1'b0;
        #1;
        check("start_abort_busy", BusyMul, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("start_abort_done", DoneMul, 1'b0);
        check_results("start_abort_keep");

        for (int k = 0; k < 20; k++) begin
            do_mul($urandom, $urandom, 1'($urandom), 4'($urandom), 4'($urandom), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
